// File: rtl/cordic_pkg.sv
// cordic_pkg: default widths, arctangent table and quadrant constant shared by the CORDIC rotator.
package cordic_pkg;
  localparam int BITWIDTH_D = 16;
  localparam int ZWIDTH_D = 16;
  localparam logic [15:0] QUAD = 16'h4000;
  localparam logic [15:0] ATAN [16] = '{
    16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326, 16'd163, 16'd81,
    16'd41, 16'd20, 16'd10, 16'd5, 16'd3, 16'd1, 16'd1, 16'd0
  };
endpackage

// File: rtl/cordic_stage.sv
// cordic_stage: one registered CORDIC micro-rotation; the z register can be omitted
// when nothing downstream consumes the residual phase.
module cordic_stage #(
  parameter int W = 18,
  parameter int ZW = 16,
  parameter int SHIFT = 0,
  parameter logic [ZW-1:0] ATAN_C = '0,
  parameter bit ZREG = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic signed [W-1:0]  x_i,
  input  logic signed [W-1:0]  y_i,
  input  logic        [ZW-1:0] z_i,
  output logic signed [W-1:0]  x_o,
  output logic signed [W-1:0]  y_o,
  output logic        [ZW-1:0] z_o
);
  logic signed [W-1:0] x_d, y_d, x_q, y_q;
  logic neg;
  assign neg = z_i[ZW-1];
  always_comb begin
    x_d = neg ? x_i + (y_i >>> SHIFT) : x_i - (y_i >>> SHIFT);
    y_d = neg ? y_i - (x_i >>> SHIFT) : y_i + (x_i >>> SHIFT);
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (enable) begin
      x_q <= x_d;
      y_q <= y_d;
    end
  assign x_o = x_q;
  assign y_o = y_q;
  if (ZREG) begin : g_z
    logic [ZW-1:0] z_d, z_q;
    assign z_d = neg ? z_i + ATAN_C : z_i - ATAN_C;
    always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) z_q <= '0;
      else if (enable) z_q <= z_d;
    assign z_o = z_q;
  end else begin : g_noz
    // only the sign bit steers this stage; the residual itself is dropped
    logic unused_z;
    assign unused_z = ^z_i[ZW-2:0];
    assign z_o = '0;
  end
endmodule

// File: rtl/cordic_rotator.sv
// cordic_rotator: fully unrolled pipelined CORDIC vector rotator, latency STAGES+1 enabled edges.
// Define CORDIC_ZO_EN to drive zo with the residual phase; otherwise zo is tied to 0.
module cordic_rotator
  import cordic_pkg::*;
#(
  parameter int BITWIDTH = BITWIDTH_D,
  parameter int ZWIDTH = ZWIDTH_D,
  parameter int STAGES = 12
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [BITWIDTH-1:0] xi,
  input  logic [BITWIDTH-1:0] yi,
  input  logic [ZWIDTH-1:0]   zi,
  output logic [BITWIDTH-1:0] xo,
  output logic [BITWIDTH-1:0] yo,
  output logic [ZWIDTH-1:0]   zo
);
`ifdef CORDIC_ZO_EN
  localparam bit ZO_EN = 1'b1;
`else
  localparam bit ZO_EN = 1'b0;
`endif
  localparam int W = BITWIDTH + 2;
  localparam logic [ZWIDTH-1:0] Q = ZWIDTH'(QUAD);
  logic signed [W-1:0] xs, ys, x_d, y_d, x_q, y_q;
  logic [ZWIDTH-1:0] z_d, z_q;
  logic [1:0] quad;
  logic signed [W-1:0] xp [STAGES+1];
  logic signed [W-1:0] yp [STAGES+1];
  logic [ZWIDTH-1:0] zp [STAGES+1];
  assign xs = W'($signed(xi));
  assign ys = W'($signed(yi));
  // quadrant pre-rotation brings the phase into +/-90 degrees
  always_comb begin
    quad = zi[ZWIDTH-1 -: 2];
    x_d = quad == 2'b01 ? -ys : quad == 2'b10 ? ys : xs;
    y_d = quad == 2'b01 ? xs : quad == 2'b10 ? -xs : ys;
    z_d = quad == 2'b01 ? zi - Q : quad == 2'b10 ? zi + Q : zi;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
    end else if (enable) begin
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
    end
  assign xp[0] = x_q;
  assign yp[0] = y_q;
  assign zp[0] = z_q;
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    cordic_stage #(
      .W(W),
      .ZW(ZWIDTH),
      .SHIFT(s),
      .ATAN_C(ZWIDTH'(ATAN[s])),
      .ZREG(ZO_EN || s != STAGES - 1)
    ) u_stage (
      .clock(clock),
      .reset_n(reset_n),
      .enable(enable),
      .x_i(xp[s]),
      .y_i(yp[s]),
      .z_i(zp[s]),
      .x_o(xp[s+1]),
      .y_o(yp[s+1]),
      .z_o(zp[s+1])
    );
  end
  assign xo = xp[STAGES][BITWIDTH:1];
  assign yo = yp[STAGES][BITWIDTH:1];
  assign zo = zp[STAGES];
  logic unused_edge_bits;
  assign unused_edge_bits = ^{xp[STAGES][W-1], xp[STAGES][0], yp[STAGES][W-1], yp[STAGES][0]};
endmodule

// File: tb/tb_cordic_rotator.sv
// tb_cordic_rotator: random and directed stimulus checked against an iterative CORDIC model.
module tb_cordic_rotator;
  localparam int STAGES = 12;
  localparam int LAT = STAGES + 1;
  localparam int ATAN_T [16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0};
  logic clock = 1'b0;
  logic reset_n, enable;
  logic [15:0] xi, yi, zi, xo, yo, zo;
  int n_cmp = 0, n_bad = 0;
  logic [47:0] pipe [$];
  logic [47:0] cur;
  bit valid = 1'b0;

  cordic_rotator dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .xi(xi), .yi(yi), .zi(zi), .xo(xo), .yo(yo), .zo(zo)
  );

  always #5 clock = ~clock;

  function automatic logic [47:0] model(input logic [15:0] x_in, y_in, z_in);
    int x, y, t;
    logic [15:0] z;
    x = int'($signed(x_in));
    y = int'($signed(y_in));
    z = z_in;
    if (z[15:14] == 2'b01) begin
      t = x; x = -y; y = t; z = z - 16'h4000;
    end else if (z[15:14] == 2'b10) begin
      t = x; x = y; y = -t; z = z + 16'h4000;
    end
    for (int i = 0; i < STAGES; i++) begin
      t = x;
      if (!z[15]) begin
        x = x - (y >>> i); y = y + (t >>> i); z = z - 16'(ATAN_T[i]);
      end else begin
        x = x + (y >>> i); y = y - (t >>> i); z = z + 16'(ATAN_T[i]);
      end
    end
`ifndef CORDIC_ZO_EN
    z = 16'h0;
`endif
    return {16'(x >>> 1), 16'(y >>> 1), z};
  endfunction

  task automatic chk(input string nm, input int act, input int exp, input int tol);
    n_cmp++;
    if (act > exp + tol || act < exp - tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (tol %0d) at %0t", nm, act, exp, tol, $time);
    end
  endtask

  function automatic int sx(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n) begin
      pipe.delete();
      valid = 1'b0;
    end else if (enable) begin
      pipe.push_back(model(xi, yi, zi));
      if (pipe.size() == LAT) begin
        cur = pipe.pop_front();
        valid = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (reset_n && valid) begin
      chk("pipe_xo", sx(xo), sx(cur[47:32]), 0);
      chk("pipe_yo", sx(yo), sx(cur[31:16]), 0);
      chk("pipe_zo", int'(zo), int'(cur[15:0]), 0);
    end
  end

  task automatic directed(input string nm, input int x, input int y, input logic [15:0] z, input int ex, input int ey);
    xi = 16'(x); yi = 16'(y); zi = z; enable = 1'b1;
    repeat (LAT) @(negedge clock);
    chk({nm, "_xo"}, sx(xo), ex, 4);
    chk({nm, "_yo"}, sx(yo), ey, 4);
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      xi = 16'($urandom_range(0, 38000) - 19000);
      yi = 16'($urandom_range(0, 38000) - 19000);
      zi = 16'($urandom);
      enable = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; xi = '0; yi = '0; zi = '0;
    repeat (3) @(negedge clock);
    chk("rst_xo", sx(xo), 0, 0);
    chk("rst_yo", sx(yo), 0, 0);
    chk("rst_zo", int'(zo), 0, 0);
    reset_n = 1'b1;
    directed("z0", 10000, 0, 16'h0000, 8234, 0);
    directed("z90", 10000, 0, 16'h4000, 0, 8234);
    directed("z180", 10000, 0, 16'h8000, -8234, 0);
    directed("z45", 10000, 0, 16'h2000, 5822, 5822);
    directed("zm45", 10000, 0, 16'hE000, 5822, -5822);
    directed("zq1", 0, 10000, 16'h0000, 0, 8234);
    xi = 16'd10000; yi = 16'd0; zi = 16'h1234;
    repeat (LAT) @(negedge clock);
`ifdef CORDIC_ZO_EN
    chk("zo_resid", sx(zo), 0, 2);
`else
    chk("zo_tied", int'(zo), 0, 0);
`endif
    rand_cycles(60);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_xo", sx(xo), 0, 0);
    chk("midrst_yo", sx(yo), 0, 0);
    chk("midrst_zo", int'(zo), 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    xi = 16'd10000; yi = 16'd0; zi = 16'h0000; enable = 1'b1;
    repeat (LAT - 1) @(negedge clock);
    chk("lat_early_xo", sx(xo), 0, 0);
    @(negedge clock);
    chk("lat_xo", sx(xo), 8234, 4);
    rand_cycles(80);
    enable = 1'b1;
    repeat (LAT + 2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
